if_fetch_queue_stage: RTL and testbench

Instruction-fetch stage with a decoupling fetch queue between instruction memory and the IF/ID boundary. Successor to the single-entry fetch stage. Adds:
- a parametrised-depth FIFO of fetched instructions;
- a valid/ready handshake toward ID, in place of a bare write-enable;
- a one-cycle-latency synchronous memory port;
- a redirect (branch/jump) flush that discards queued and in-flight fetches.

---
 rtl/core_pkg.sv | 18 +
 rtl/fetch_queue.sv | 63 ++++++
 rtl/if_fetch_queue_stage.sv | 121 ++++++++++++
 tb/tb_if_fetch_queue_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions for the fetch path.
// Contents:
//   DATA_WIDTH, INST_MEM_ADDR_WIDTH - datapath and instruction-memory word-address widths
//   FQ_DEPTH_DEFAULT                - default fetch-queue depth
//   if_id_data_t                    - {pc, pc_plus4, instruction} passed across IF/ID
package core_pkg;

  localparam int unsigned DATA_WIDTH          = 32;
  localparam int unsigned INST_MEM_ADDR_WIDTH = 10;
  localparam int unsigned FQ_DEPTH_DEFAULT    = 4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] instruction;
  } if_id_data_t;

endpackage

// File: rtl/fetch_queue.sv
// First-word-fall-through FIFO of fetched instructions.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   flush_i      - clear all entries; overrides push and pop this cycle
//   push_i       - write push_data_i at the tail (caller guarantees not full)
//   push_data_i  - entry to write
//   pop_i        - drop the head entry (ignored when empty)
//   head_o       - current head entry, valid while count_o != 0
//   count_o      - occupancy, 0..Depth
module fetch_queue
  import core_pkg::*;
#(
  parameter int unsigned Depth = FQ_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  if_id_data_t            push_data_i,
  input  logic                   pop_i,
  output if_id_data_t            head_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  if_id_data_t     mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;

  // Depth is a power of two, so natural pointer overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; stale entries are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_queue_stage.sv
// Instruction-fetch stage with a decoupling fetch queue toward ID.
// Holds the fetch PC, the credit-based issue logic, in-flight tracking for the
// one-cycle-latency instruction memory, and optional performance counters.
// Optional feature macro: IF_PERF_CNT_EN adds perf_fetch_cnt_o / perf_stall_cnt_o.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   redirect_i        - flush queue and in-flight fetch, restart at redirect_pc_i
//   redirect_pc_i     - redirect target (low two bits ignored)
//   imem_req_o        - instruction-memory read request this cycle
//   imem_addr_o       - word address of the request
//   imem_rdata_i      - read data, valid the cycle after the request
//   out_valid_o       - queue head valid toward ID
//   out_ready_i       - ID accepts the head
//   out_data_o        - {pc, pc_plus4, instruction} of the head
//   perf_fetch_cnt_o  - (IF_PERF_CNT_EN) instructions pushed into the queue
//   perf_stall_cnt_o  - (IF_PERF_CNT_EN) cycles with head valid but not accepted
//   fq_count_o        - queue occupancy
module if_fetch_queue_stage
  import core_pkg::if_id_data_t;
#(
  parameter int unsigned                      DATA_WIDTH          = core_pkg::DATA_WIDTH,
  parameter int unsigned                      INST_MEM_ADDR_WIDTH = core_pkg::INST_MEM_ADDR_WIDTH,
  parameter int unsigned                      FQ_DEPTH            = core_pkg::FQ_DEPTH_DEFAULT,
  parameter logic [core_pkg::DATA_WIDTH-1:0] RESET_PC            = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           redirect_i,
  input  logic [DATA_WIDTH-1:0]          redirect_pc_i,
  output logic                           imem_req_o,
  output logic [INST_MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0]          imem_rdata_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output if_id_data_t                    out_data_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]                    perf_fetch_cnt_o,
  output logic [31:0]                    perf_stall_cnt_o,
`endif
  output logic [$clog2(FQ_DEPTH):0]      fq_count_o
);

  localparam int unsigned CntW = $clog2(FQ_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] fetch_pc_q;
  logic [DATA_WIDTH-1:0] inflight_pc_q;
  logic                  inflight_q;
  logic [CntW-1:0]       fq_count;
  logic [CntW:0]         credit_used;
  logic                  push;
  logic                  pop;
  if_id_data_t           push_data;
  logic                  unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // An issued request reserves a slot, so the response can never find the queue full.
  assign credit_used = {1'b0, fq_count} + {{CntW{1'b0}}, inflight_q};
  assign imem_req_o  = !rst && !redirect_i && (credit_used < (CntW + 1)'(FQ_DEPTH));
  assign imem_addr_o = fetch_pc_q[INST_MEM_ADDR_WIDTH+1:2];

  // A response landing in a redirect cycle belongs to the old path and is dropped.
  assign push                  = inflight_q && !redirect_i;
  assign push_data.pc          = inflight_pc_q;
  assign push_data.pc_plus4    = inflight_pc_q + DATA_WIDTH'(4);
  assign push_data.instruction = imem_rdata_i;

  assign out_valid_o = (fq_count != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign fq_count_o  = fq_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc_q <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= imem_req_o;
      if (imem_req_o) begin
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + DATA_WIDTH'(4);
      end
    end
  end

  fetch_queue #(
    .Depth (FQ_DEPTH)
  ) u_fetch_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (out_data_o),
    .count_o     (fq_count)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_q;
  logic [31:0] perf_stall_cnt_q;

  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt_q <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      if (push)                       perf_fetch_cnt_q <= perf_fetch_cnt_q + 32'd1;
      if (out_valid_o && !out_ready_i) perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_cnt_q;
  assign perf_stall_cnt_o = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue_stage.sv
// Directed bench for if_fetch_queue_stage. Memory returns address-tagged words:
// instruction = 32'hA000_0000 | byte address bits [11:2].
module tb_if_fetch_queue_stage;
  import core_pkg::*;

  logic        clk;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [9:0]  imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        out_valid_o;
  logic        out_ready_i;
  if_id_data_t out_data_o;
  logic [2:0]  fq_count_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_queue_stage dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o),
`endif
    .fq_count_o    (fq_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency memory model.
  always @(posedge clk) begin
    if (imem_req_o) imem_rdata_i <= 32'hA000_0000 | {20'h0, imem_addr_o, 2'b00};
  end

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return 32'hA000_0000 | (pc & 32'h0000_0FFC);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the head carries the given pc with consistent pc_plus4 and instruction.
  task automatic expect_head(input string name, input logic [31:0] pc);
    n_cmp++;
    if (out_valid_o !== 1'b1 || out_data_o.pc !== pc || out_data_o.pc_plus4 !== pc + 32'd4 ||
        out_data_o.instruction !== exp_inst(pc)) begin
      n_err++;
      $display("FAIL %s: got valid=%b pc=%h pc4=%h inst=%h, want valid=1 pc=%h pc4=%h inst=%h",
               name, out_valid_o, out_data_o.pc, out_data_o.pc_plus4, out_data_o.instruction,
               pc, pc + 32'd4, exp_inst(pc));
    end
  endtask

  task automatic release_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; out_ready_i = 1'b1;
    step();
    step();
    n_cmp++;
    if (imem_req_o !== 1'b0 || out_valid_o !== 1'b0 || fq_count_o !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got req=%b valid=%b count=%0d, want 0 0 0",
               imem_req_o, out_valid_o, fq_count_o);
    end
  endtask

  task automatic test_stream();
    out_ready_i = 1'b1;
    release_reset();
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 10'h000) begin
      n_err++;
      $display("FAIL stream_c0_req: got req=%b addr=%h, want 1 000", imem_req_o, imem_addr_o);
    end
    step();
    n_cmp++;
    if (out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL stream_c1_valid: got %b, want 0", out_valid_o);
    end
    step();
    for (int k = 0; k < 6; k++) begin
      expect_head("stream_head", 32'(4 * k));
      n_cmp++;
      if (fq_count_o !== 3'd1) begin
        n_err++;
        $display("FAIL stream_count: got %0d, want 1", fq_count_o);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int reqs = 0;
    out_ready_i = 1'b0;
    release_reset();
    for (int k = 0; k < 10; k++) begin
      if (imem_req_o === 1'b1) reqs++;
      step();
    end
    n_cmp++;
    if (reqs != 4 || fq_count_o !== 3'd4 || imem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL bp_fill: got reqs=%0d count=%0d req=%b, want 4 4 0",
               reqs, fq_count_o, imem_req_o);
    end
    out_ready_i = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      expect_head("bp_drain", 32'(4 * k));
      step();
    end
  endtask

  task automatic test_redirect();
    out_ready_i = 1'b0;
    release_reset();
    repeat (4) step();
    n_cmp++;
    if (fq_count_o !== 3'd3) begin
      n_err++;
      $display("FAIL redir_setup_count: got %0d, want 3", fq_count_o);
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102;
    #1;
    n_cmp++;
    if (imem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL redir_t_req: got %b, want 0", imem_req_o);
    end
    step();
    redirect_i = 1'b0;
    #1;
    n_cmp++;
    if (out_valid_o !== 1'b0 || fq_count_o !== 3'd0 || imem_req_o !== 1'b1 ||
        imem_addr_o !== 10'h040) begin
      n_err++;
      $display("FAIL redir_t1: got valid=%b count=%0d req=%b addr=%h, want 0 0 1 040",
               out_valid_o, fq_count_o, imem_req_o, imem_addr_o);
    end
    step();
    n_cmp++;
    if (out_valid_o !== 1'b0 || fq_count_o !== 3'd0) begin
      n_err++;
      $display("FAIL redir_t2: got valid=%b count=%0d, want 0 0", out_valid_o, fq_count_o);
    end
    step();
    expect_head("redir_t3", 32'h0000_0100);
    out_ready_i = 1'b1;
    step();
    expect_head("redir_t4", 32'h0000_0104);
  endtask

  task automatic test_back_to_back_redirect();
    out_ready_i = 1'b1;
    repeat (3) step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    step();
    redirect_pc_i = 32'h0000_0300;
    step();
    redirect_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (out_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_gap: cycle %0d got valid=%b pc=%h, want 0", k, out_valid_o,
                 out_data_o.pc);
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      expect_head("b2b_head", 32'h0000_0300 + 32'(4 * k));
      step();
    end
  endtask

  task automatic test_wrap();
    out_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    step();
    step();
    n_cmp++;
    if (out_data_o.pc_plus4 !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL wrap_pc_plus4: got %h, want 00000000", out_data_o.pc_plus4);
    end
    expect_head("wrap_first", 32'hFFFF_FFFC);
    step();
    expect_head("wrap_second", 32'h0000_0000);
  endtask

  task automatic test_mid_reset();
    out_ready_i = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_req: got %b, want 0", imem_req_o);
    end
    step();
    n_cmp++;
    if (out_valid_o !== 1'b0 || fq_count_o !== 3'd0) begin
      n_err++;
      $display("FAIL midrst_state: got valid=%b count=%0d, want 0 0", out_valid_o, fq_count_o);
    end
    rst = 1'b0;
    out_ready_i = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 10'h000) begin
      n_err++;
      $display("FAIL midrst_c0: got req=%b addr=%h, want 1 000", imem_req_o, imem_addr_o);
    end
    step();
    n_cmp++;
    if (out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_c1: got valid=%b, want 0", out_valid_o);
    end
    step();
    expect_head("midrst_c2", 32'h0000_0000);
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    out_ready_i = 1'b1;
    release_reset();
    repeat (7) step();
    n_cmp++;
    if (perf_fetch_cnt_o !== 32'd6 || perf_stall_cnt_o !== 32'd0) begin
      n_err++;
      $display("FAIL perf_stream: got fetch=%0d stall=%0d, want 6 0",
               perf_fetch_cnt_o, perf_stall_cnt_o);
    end
    out_ready_i = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (perf_fetch_cnt_o !== 32'd9 || perf_stall_cnt_o !== 32'd3) begin
      n_err++;
      $display("FAIL perf_stall: got fetch=%0d stall=%0d, want 9 3",
               perf_fetch_cnt_o, perf_stall_cnt_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (perf_fetch_cnt_o !== 32'd0 || perf_stall_cnt_o !== 32'd0) begin
      n_err++;
      $display("FAIL perf_reset: got fetch=%0d stall=%0d, want 0 0",
               perf_fetch_cnt_o, perf_stall_cnt_o);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; out_ready_i = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back_redirect();
    test_wrap();
    test_mid_reset();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
